// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer: CORDIC iteration control FSM driving load mux, stage enables, iteration index and rotation direction.
// Define CORDIC_SEQ_ABORT_EN to add the abort input that cancels an operation in flight.
module cordic_iter_sequencer #(
  parameter int ITERATIONS = 16,
  parameter int ITER_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic              z_sign,
  input  logic              y_sign,
  output logic              load_sel,
  output logic              reg_en,
  output logic [ITER_W-1:0] iter,
  output logic              rot_dir,
  output logic              out_valid,
`ifdef CORDIC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              out_ready
);
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;
  localparam logic [ITER_W-1:0] LAST = ITER_W'(ITERATIONS - 1);
  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              mode_q, mode_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    mode_d   = mode_q;
    load_sel = 1'b0;
    reg_en   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        load_sel = 1'b1;
        reg_en   = 1'b1;
        mode_d   = in_mode;
        iter_d   = '0;
        state_d  = ITER;
      end
      ITER: begin
        reg_en  = 1'b1;
        state_d = (iter_q == LAST) ? DONE : ITER;
        iter_d  = (iter_q == LAST) ? iter_q : iter_q + 1'b1;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        iter_d  = '0;
      end
      default: state_d = IDLE;
    endcase
`ifdef CORDIC_SEQ_ABORT_EN
    // Abort wins over out_ready and freezes the stage registers this cycle
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      iter_d  = '0;
      reg_en  = 1'b0;
    end
`endif
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign iter      = iter_q;
  assign rot_dir   = (state_q == ITER) ? (mode_q ? y_sign : ~z_sign) : 1'b0;
endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// tb_cordic_iter_sequencer: table-driven operations with a per-iteration scoreboard plus reset/busy/abort sequences.
module tb_cordic_iter_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_mode = 1'b0, z_sign = 1'b0, y_sign = 1'b0, out_ready = 1'b0;
  logic       in_ready, load_sel, reg_en, rot_dir, out_valid;
  logic [3:0] iter;
`ifdef CORDIC_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  int         total = 0, passed = 0;

  typedef struct {logic mode; logic z; logic y; logic pulse; int bp; logic dir;} vec_t;
  typedef struct {logic [3:0] it; logic dir;} exp_t;
  vec_t vecs[4];
  exp_t sb[$];

  cordic_iter_sequencer #(.ITERATIONS(16), .ITER_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .z_sign(z_sign), .y_sign(y_sign), .load_sel(load_sel), .reg_en(reg_en), .iter(iter),
    .rot_dir(rot_dir), .out_valid(out_valid),
`ifdef CORDIC_SEQ_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s got %0d want %0d", nm, a, e);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iters(input int n, input logic dir);
    for (int i = 0; i < n; i++) sb.push_back('{it: 4'(i), dir: dir});
  endtask

  always @(negedge clk) begin
    if (rst && reg_en && !load_sel) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_iter", iter, e.it);
        chk("sb_rot_dir", rot_dir, e.dir);
      end
    end else if (rst && !reg_en) chk("rot_dir_quiet", rot_dir, 0);
  end

  task automatic start_op(input logic mode, input logic z, input logic y);
    in_valid = 1'b1; in_mode = mode; z_sign = z; y_sign = y;
    #1;
    chk("accept_in_ready", in_ready, 1);
    chk("accept_load_sel", load_sel, 1);
    chk("accept_reg_en", reg_en, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int n = 0;
    out_ready = 1'b0;
    push_iters(16, v.dir);
    start_op(v.mode, v.z, v.y);
    while (!out_valid && n < 40) begin
      chk("busy_in_ready", in_ready, 0);
      in_valid = v.pulse && (iter == 4'd7);
      in_mode  = ~in_mode;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 16);
    chk("sb_drained", sb.size(), 0);
    repeat (v.bp) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_reg_en", reg_en, 0);
      chk("bp_iter_hold", iter, 15);
      tick();
    end
    chk("done_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_in_ready", in_ready, 1);
    chk("ret_out_valid", out_valid, 0);
    chk("ret_iter", iter, 0);
  endtask

  task automatic wait_iter(input logic [3:0] t);
    int n = 0;
    while (iter != t && n < 40) begin tick(); n++; end
    chk("wait_iter", iter, t);
  endtask

  initial begin
    vecs[0] = '{mode: 0, z: 0, y: 1, pulse: 0, bp: 0, dir: 1};
    vecs[1] = '{mode: 0, z: 1, y: 0, pulse: 1, bp: 5, dir: 0};
    vecs[2] = '{mode: 1, z: 0, y: 1, pulse: 0, bp: 2, dir: 1};
    vecs[3] = '{mode: 1, z: 1, y: 0, pulse: 1, bp: 0, dir: 0};
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg_en", reg_en, 0);
    chk("rst_iter", iter, 0);
    chk("rst_load_sel", load_sel, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_no_valid_reg_en", reg_en, 0);
    for (int i = 0; i < 4; i++) run_op(vecs[i]);

    push_iters(9, 1'b1);
    start_op(1'b0, 1'b0, 1'b0);
    wait_iter(4'd9);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_reg_en", reg_en, 0);
    chk("mid_rst_iter", iter, 0);
    repeat (3) begin tick(); chk("mid_rst_out_valid", out_valid, 0); end
    rst = 1'b1;
    chk("mid_rst_sb", sb.size(), 0);
    tick();
    run_op(vecs[0]);

`ifdef CORDIC_SEQ_ABORT_EN
    push_iters(4, 1'b0);
    start_op(1'b1, 1'b0, 1'b0);
    wait_iter(4'd4);
    abort = 1'b1;
    #1;
    chk("abort_reg_en", reg_en, 0);
    tick();
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_iter", iter, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sb", sb.size(), 0);
    run_op(vecs[2]);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d want %0d", 0, 1);
    $fatal(1);
  end
endmodule
